// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//   Single-outstanding APB master. A valid/ready command becomes one APB
//   SETUP/ACCESS transfer to the slave that the address index field selects.
//   The result comes back as a one-cycle response pulse. Hung transfers are
//   aborted after TIMEOUT ACCESS cycles with pready low.
//
// Ports
//   i_pclk, i_prstn          : APB clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready  : command handshake
//   i_cmd_write/addr/wdata   : command payload
//   o_rsp_valid/rdata/err    : one-cycle transfer result (rdata/err held)
//   o_paddr/pwrite/pwdata    : shared APB bus, held between transfers
//   o_psel/o_penable         : one-hot slave select, enable
//   i_prdata/pready/pslverr  : packed per-slave return signals
module apb_master_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SLV_NUM    = 4,
  parameter int SLV_LSB    = 7,
  parameter int TIMEOUT    = 15
) (
  input  logic                          i_pclk,
  input  logic                          i_prstn,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]         i_cmd_addr,
  input  logic [DATA_WIDTH-1:0]         i_cmd_wdata,
  output logic                          o_rsp_valid,
  output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic [ADDR_WIDTH-1:0]         o_paddr,
  output logic                          o_pwrite,
  output logic [SLV_NUM-1:0]            o_psel,
  output logic                          o_penable,
  output logic [DATA_WIDTH-1:0]         o_pwdata,
  input  logic [SLV_NUM*DATA_WIDTH-1:0] i_prdata,
  input  logic [SLV_NUM-1:0]            i_pready,
  input  logic [SLV_NUM-1:0]            i_pslverr
);

  localparam int IDXW = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam int ALSB = $clog2(DATA_WIDTH / 8);
  localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic [TW-1:0]   r_tcnt;
  logic            r_dec_err;

  logic [IDXW-1:0]       w_idx;
  logic [SLV_NUM-1:0]    w_onehot;
  logic                  w_misalign;
  logic                  w_dec_err;
  logic                  w_sel_ready;
  logic                  w_sel_err;
  logic [DATA_WIDTH-1:0] w_sel_rdata;
  logic                  w_timeout;

  assign w_idx    = i_cmd_addr[SLV_LSB +: IDXW];
  assign w_onehot = SLV_NUM'(1) << w_idx;

  generate
    if (ALSB > 0) begin : g_align
      assign w_misalign = |i_cmd_addr[ALSB-1:0];
    end else begin : g_noalign
      assign w_misalign = 1'b0;
    end
  endgenerate

  assign w_dec_err = (32'(w_idx) >= 32'(SLV_NUM)) || w_misalign;

  // Only the addressed slave's return signals are looked at.
  assign w_sel_ready = i_pready[r_idx];
  assign w_sel_err   = i_pslverr[r_idx];
  assign w_sel_rdata = i_prdata[int'(r_idx) * DATA_WIDTH +: DATA_WIDTH];

  // Abort on the ACCESS edge at which the low-pready count would reach TIMEOUT.
  assign w_timeout = (TIMEOUT != 0) && ((32'(r_tcnt) + 32'd1) == 32'(TIMEOUT));

  always_ff @(posedge i_pclk or negedge i_prstn) begin
    if (!i_prstn) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_tcnt      <= '0;
      r_dec_err   <= 1'b0;
      o_cmd_ready <= 1'b1;
      o_psel      <= '0;
      o_penable   <= 1'b0;
      o_pwrite    <= 1'b0;
      o_paddr     <= '0;
      o_pwdata    <= '0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_cmd_valid) begin
            o_cmd_ready <= 1'b0;
            o_pwrite    <= i_cmd_write;
            o_paddr     <= i_cmd_addr;
            o_pwdata    <= i_cmd_wdata;
            r_idx       <= w_idx;
            if (w_dec_err) begin
              r_dec_err <= 1'b1;
              r_state   <= RESP;
            end else begin
              r_tcnt  <= '0;
              o_psel  <= w_onehot;
              r_state <= SETUP;
            end
          end
        end
        SETUP: begin
          o_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_sel_ready) begin
            o_psel      <= '0;
            o_penable   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= w_sel_err;
            o_rsp_rdata <= (!o_pwrite && !w_sel_err) ? w_sel_rdata : '0;
            r_state     <= RESP;
          end else if (w_timeout) begin
            o_psel      <= '0;
            o_penable   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= '0;
            r_state     <= RESP;
          end else if (TIMEOUT != 0) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        RESP: begin
          // A decode error enters RESP without a pulse; it is raised here,
          // so the pulse follows the accept by one cycle and RESP lasts two.
          if (r_dec_err) begin
            r_dec_err   <= 1'b0;
            o_rsp_valid <= 1'b1;
            o_rsp_err   <= 1'b1;
            o_rsp_rdata <= '0;
          end else begin
            o_rsp_valid <= 1'b0;
            o_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//   Directed bench for apb_master_bridge with four behavioural APB slaves
//   (programmable wait states, stuck pready, pslverr modes) and a
//   transaction-level expectation model checked every cycle.
module tb_apb_master_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NS = 4;
  localparam int TO = 15;

  logic           clk;
  logic           rstn;
  logic           cmd_valid;
  logic           cmd_ready;
  logic           cmd_write;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;
  logic           rsp_valid;
  logic [DW-1:0]  rsp_rdata;
  logic           rsp_err;
  logic [AW-1:0]  paddr;
  logic           pwrite;
  logic [NS-1:0]  psel;
  logic           penable;
  logic [DW-1:0]  pwdata;
  logic [NS*DW-1:0] prdata;
  logic [NS-1:0]  pready;
  logic [NS-1:0]  pslverr;

  int tests = 0;
  int fails = 0;

  apb_master_bridge #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLV_NUM(NS), .SLV_LSB(7), .TIMEOUT(TO)
  ) dut (
    .i_pclk(clk), .i_prstn(rstn),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_paddr(paddr), .o_pwrite(pwrite), .o_psel(psel), .o_penable(penable),
    .o_pwdata(pwdata), .i_prdata(prdata), .i_pready(pready), .i_pslverr(pslverr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural slaves ----------------
  int   wait_cfg [NS];     // low-pready ACCESS cycles before ready
  int   err_mode [NS];     // 0 none, 1 pslverr with pready, 2 pslverr only while waiting
  bit   stuck    [NS];
  int   acc_cnt  [NS];
  logic [DW-1:0] smem [NS][32];
  bit   swr      [NS][32];

  function automatic logic [31:0] pattern(input int k, input int w);
    return 32'hA000_0000 | (32'(k) << 8) | 32'(w);
  endfunction

  always_comb begin
    prdata  = '0;
    pready  = '0;
    pslverr = '0;
    for (int k = 0; k < NS; k++) begin
      pready[k]  = !stuck[k] && (acc_cnt[k] >= wait_cfg[k]);
      pslverr[k] = (err_mode[k] == 1 && pready[k]) || (err_mode[k] == 2 && !pready[k]);
      prdata[k*DW +: DW] = swr[k][paddr[6:2]] ? smem[k][paddr[6:2]] : pattern(k, int'(paddr[6:2]));
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (psel[k] && penable && !pready[k]) acc_cnt[k] <= acc_cnt[k] + 1;
      else if (!psel[k]) acc_cnt[k] <= 0;
      if (psel[k] && penable && pready[k] && pwrite) begin
        smem[k][paddr[6:2]] <= pwdata;
        swr[k][paddr[6:2]]  <= 1'b1;
      end
    end
  end

  // ---------------- transaction-level model + per-cycle compare ----------------
  logic [31:0] exp_mem [NS][32];
  bit          m_busy;
  bit          m_dec;
  int          m_t, m_rsp_t, m_idx;
  logic [31:0] m_rdata;
  logic        m_err;
  logic [31:0] e_paddr, e_pwdata, e_rdata;
  logic        e_pwrite, e_err;

  initial begin
    logic [NS-1:0] e_psel;
    logic          e_pen, e_rv, e_ready;
    int            a, word;
    bit            abort;
    for (int k = 0; k < NS; k++)
      for (int w = 0; w < 32; w++) exp_mem[k][w] = pattern(k, w);
    m_busy = 0; m_dec = 0; m_t = 0; m_rsp_t = 0; m_idx = 0;
    m_rdata = '0; m_err = 0;
    e_paddr = '0; e_pwdata = '0; e_rdata = '0; e_pwrite = 0; e_err = 0;
    forever begin
      @(posedge clk);
      if (!rstn) begin
        m_busy = 0; e_paddr = '0; e_pwdata = '0; e_pwrite = 0; e_rdata = '0; e_err = 0;
      end else if (!m_busy) begin
        if (cmd_valid) begin
          m_busy   = 1;
          m_t      = 0;
          m_idx    = int'((cmd_addr / 128) % NS);
          word     = int'((cmd_addr / 4) % 32);
          e_paddr  = cmd_addr;
          e_pwrite = cmd_write;
          e_pwdata = cmd_wdata;
          m_dec    = (cmd_addr % 4) != 0 || m_idx >= NS;
          if (m_dec) begin
            m_rsp_t = 1; m_err = 1; m_rdata = '0;
          end else begin
            abort = stuck[m_idx] || (wait_cfg[m_idx] + 1 > TO);
            a = abort ? TO : wait_cfg[m_idx] + 1;
            m_rsp_t = a + 1;
            m_err   = abort || err_mode[m_idx] == 1;
            m_rdata = (!cmd_write && !m_err) ? exp_mem[m_idx][word] : '0;
            if (cmd_write && !abort) exp_mem[m_idx][word] = cmd_wdata;
          end
        end
      end else begin
        m_t++;
        if (m_t == m_rsp_t) begin e_rdata = m_rdata; e_err = m_err; end
        if (m_t == m_rsp_t + 1) m_busy = 0;
      end
      #1;
      e_ready = !m_busy;
      e_psel  = '0;
      e_pen   = 0;
      if (m_busy && !m_dec && m_t < m_rsp_t) begin
        e_psel = NS'(1) << m_idx;
        e_pen  = m_t > 0;
      end
      e_rv = m_busy && (m_t == m_rsp_t);
      check("cmd_ready", 64'(cmd_ready), 64'(e_ready));
      check("psel",      64'(psel),      64'(e_psel));
      check("penable",   64'(penable),   64'(e_pen));
      check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      check("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
      check("rsp_err",   64'(rsp_err),   64'(e_err));
      check("paddr",     64'(paddr),     64'(e_paddr));
      check("pwrite",    64'(pwrite),    64'(e_pwrite));
      check("pwdata",    64'(pwdata),    64'(e_pwdata));
    end
  end

  // ---------------- driver ----------------
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output int nsel, output int npen,
                        output logic [31:0] rd, output logic er);
    int guard;
    lat = -1; nsel = 0; npen = 0; rd = '0; er = 0;
    @(negedge clk);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("accept_bound", 64'(0), 64'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    if (psel != '0) nsel++;
    if (penable) npen++;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err;
        break;
      end
      if (psel != '0) nsel++;
      if (penable) npen++;
    end
    if (lat < 0) check("rsp_bound", 64'(0), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nsel, npen, nrv, guard;
    logic [31:0] rd;
    logic er;
    for (int k = 0; k < NS; k++) begin
      wait_cfg[k] = 0; err_mode[k] = 0; stuck[k] = 0;
    end
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    check("reset_psel", 64'(psel), 64'(0));
    rstn = 1'b1;

    // write then read, slave 1 word 1, zero wait
    do_cmd(1'b1, 32'h0000_0084, 32'hDEADBEEF, lat, nsel, npen, rd, er);
    check("wr_latency", 64'(lat), 64'(2));
    check("wr_psel_cycles", 64'(nsel), 64'(2));
    check("wr_penable_cycles", 64'(npen), 64'(1));
    check("wr_err", 64'(er), 64'(0));
    check("wr_rdata", 64'(rd), 64'(0));
    do_cmd(1'b0, 32'h0000_0084, 32'h0, lat, nsel, npen, rd, er);
    check("rd_latency", 64'(lat), 64'(2));
    check("rd_data", 64'(rd), 64'hDEADBEEF);
    check("rd_err", 64'(er), 64'(0));

    // slave 2 with two wait states: ACCESS spans three cycles
    wait_cfg[2] = 2;
    do_cmd(1'b0, 32'h0000_0104, 32'h0, lat, nsel, npen, rd, er);
    check("wait_latency", 64'(lat), 64'(4));
    check("wait_penable_cycles", 64'(npen), 64'(3));
    check("wait_data", 64'(rd), 64'hA000_0201);
    check("wait_err", 64'(er), 64'(0));

    // stuck slave 3: abort after TIMEOUT ACCESS cycles
    stuck[3] = 1;
    do_cmd(1'b0, 32'h0000_0180, 32'h0, lat, nsel, npen, rd, er);
    check("to_penable_cycles", 64'(npen), 64'(15));
    check("to_latency", 64'(lat), 64'(16));
    check("to_err", 64'(er), 64'(1));
    check("to_rdata", 64'(rd), 64'(0));
    stuck[3] = 0;

    // decode errors: misaligned read and misaligned write never touch the bus
    do_cmd(1'b0, 32'h0000_0002, 32'h0, lat, nsel, npen, rd, er);
    check("dec_latency", 64'(lat), 64'(1));
    check("dec_psel_cycles", 64'(nsel), 64'(0));
    check("dec_err", 64'(er), 64'(1));
    do_cmd(1'b1, 32'h0000_0086, 32'h1234_5678, lat, nsel, npen, rd, er);
    check("dec_wr_err", 64'(er), 64'(1));
    check("dec_wr_psel_cycles", 64'(nsel), 64'(0));
    // with a 2-bit index field 0x200 aliases slave 0, word 0
    do_cmd(1'b0, 32'h0000_0200, 32'h0, lat, nsel, npen, rd, er);
    check("alias_data", 64'(rd), 64'hA000_0000);
    check("alias_err", 64'(er), 64'(0));

    // pslverr with pready
    err_mode[0] = 1;
    do_cmd(1'b0, 32'h0000_0008, 32'h0, lat, nsel, npen, rd, er);
    check("slverr_err", 64'(er), 64'(1));
    check("slverr_rdata", 64'(rd), 64'(0));
    // pslverr only during wait states is ignored
    err_mode[0] = 2; wait_cfg[0] = 2;
    do_cmd(1'b0, 32'h0000_0008, 32'h0, lat, nsel, npen, rd, er);
    check("slverr_wait_err", 64'(er), 64'(0));
    check("slverr_wait_data", 64'(rd), 64'hA000_0002);
    check("slverr_wait_latency", 64'(lat), 64'(4));
    err_mode[0] = 0; wait_cfg[0] = 0;

    // reset during ACCESS
    stuck[3] = 1;
    @(negedge clk);
    cmd_write = 1'b0; cmd_addr = 32'h0000_0180; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_reset_penable", 64'(penable), 64'(1));
    rstn = 1'b0;
    #1;
    check("arst_psel", 64'(psel), 64'(0));
    check("arst_penable", 64'(penable), 64'(0));
    check("arst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    nrv = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rsp_valid) nrv++;
    end
    check("arst_no_rsp", 64'(nrv), 64'(0));
    stuck[3] = 0;

    do_cmd(1'b0, 32'h0000_0084, 32'h0, lat, nsel, npen, rd, er);
    check("post_reset_latency", 64'(lat), 64'(2));
    check("post_reset_data", 64'(rd), 64'hDEADBEEF);
    check("post_reset_err", 64'(er), 64'(0));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
